// File: rtl/imem_load_arbiter.sv
// Instruction-memory port owner: passes CPU fetch addresses to the ROM in run mode,
// and streams UART bytes into ROM words (CPU held in reset) in load mode.
module imem_load_arbiter #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned MAX_WORDS   = 16384,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode_sw,
  input  logic              uart_valid,
  input  logic [7:0]        uart_byte,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_we,
  output logic [31:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {S_RUN, S_LOAD, S_RELEASE} state_t;

  state_t              state;
  state_t              state_next;
  logic                mode_meta;
  logic                mode_s;
  logic [31:0]         shreg;
  logic [1:0]          byte_cnt;
  logic                pend;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                enter_load;
  logic                leave_load;
  logic                byte_take;
  logic                hold_done;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= S_RUN;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_RUN:     if (mode_s) state_next = S_LOAD;
      S_LOAD:    if (!mode_s) state_next = S_RELEASE;
      S_RELEASE: if (hold_cnt == HOLD_LAST) state_next = S_RUN;
      default:   state_next = S_RUN;
    endcase
  end

  // ROM address mux and per-state strobes; word_count doubles as the write pointer
  always_comb begin
    rom_addr   = fetch_addr;
    enter_load = 1'b0;
    leave_load = 1'b0;
    byte_take  = 1'b0;
    hold_done  = 1'b0;
    case (state)
      S_RUN: begin
        enter_load = mode_s;
        if (rom_we) rom_addr = word_count[ADDR_W-1:0];
      end
      S_LOAD: begin
        rom_addr   = word_count[ADDR_W-1:0];
        byte_take  = uart_valid;
        leave_load = !mode_s;
      end
      S_RELEASE: begin
        rom_addr  = word_count[ADDR_W-1:0];
        hold_done = (hold_cnt == HOLD_LAST);
      end
      default: ;
    endcase
  end

  // Synchronizer, byte assembly, write pulse and sticky status
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_meta  <= 1'b0;
      mode_s     <= 1'b0;
      cpu_reset  <= 1'b0;
      rom_we     <= 1'b0;
      rom_wdata  <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
      pend       <= 1'b0;
      hold_cnt   <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mode_meta <= mode_sw;
      mode_s    <= mode_meta;
      cpu_reset <= (state_next != S_RUN);
      rom_we    <= pend;
      pend      <= 1'b0;
      if (pend) rom_wdata <= shreg;
      if (rom_we) word_count <= word_count + CNT_W'(1);
      hold_cnt <= (state == S_RELEASE) ? hold_cnt + HOLD_W'(1) : '0;
      if (hold_done) load_done <= 1'b1;
      if (byte_take) begin
        shreg    <= {shreg[23:0], uart_byte};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          if (word_count < MAX_CNT) pend <= 1'b1;
          else                      overflow <= 1'b1;
        end
      end
      // A partial word at exit is discarded
      if (leave_load) byte_cnt <= '0;
      if (enter_load) begin
        word_count <= '0;
        byte_cnt   <= '0;
        pend       <= 1'b0;
        load_done  <= 1'b0;
        overflow   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: a default instance plus a MAX_WORDS=2 instance share stimulus;
// ROM writes are collected and compared against a per-load word model.
module tb_imem_load_arbiter;
  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned HOLD      = 4;
  localparam int unsigned SMALL_MAX = 2;
  localparam int          EXIT_EDGES = 2 + HOLD + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              mode_sw = 1'b0;
  logic              uart_valid = 1'b0;
  logic [7:0]        uart_byte = 8'h00;
  logic [ADDR_W-1:0] fetch_addr = '0;

  logic [ADDR_W-1:0] rom_addr, rom_addr_s;
  logic              rom_we, rom_we_s;
  logic [31:0]       rom_wdata, rom_wdata_s;
  logic              cpu_reset, cpu_reset_s;
  logic              load_done, load_done_s;
  logic              overflow, overflow_s;
  logic [ADDR_W:0]   word_count, word_count_s;

  imem_load_arbiter #(.ADDR_W(ADDR_W), .MAX_WORDS(16384), .HOLD_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset), .mode_sw(mode_sw), .uart_valid(uart_valid),
    .uart_byte(uart_byte), .fetch_addr(fetch_addr), .rom_addr(rom_addr), .rom_we(rom_we),
    .rom_wdata(rom_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
    .overflow(overflow), .word_count(word_count));

  imem_load_arbiter #(.ADDR_W(ADDR_W), .MAX_WORDS(SMALL_MAX), .HOLD_CYCLES(HOLD)) dut_s (
    .clock(clock), .reset(reset), .mode_sw(mode_sw), .uart_valid(uart_valid),
    .uart_byte(uart_byte), .fetch_addr(fetch_addr), .rom_addr(rom_addr_s), .rom_we(rom_we_s),
    .rom_wdata(rom_wdata_s), .cpu_reset(cpu_reset_s), .load_done(load_done_s),
    .overflow(overflow_s), .word_count(word_count_s));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    int          nb;
    logic [7:0]  b [8];
    int          nw;
    logic [31:0] w0;
  } vec_t;

  wr_t        q_main[$];
  wr_t        q_small[$];
  logic [7:0] sent[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Each negedge with rom_we high is one observed write cycle
  always @(negedge clock) begin
    if (rom_we)   q_main.push_back({rom_addr, rom_wdata});
    if (rom_we_s) q_small.push_back({rom_addr_s, rom_wdata_s});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_valid = 1'b1;
    uart_byte  = b;
    sent.push_back(b);
    cyc(1);
    uart_valid = 1'b0;
  endtask

  task automatic start_session();
    q_main.delete();
    q_small.delete();
    sent.delete();
  endtask

  task automatic enter_load();
    mode_sw = 1'b1;
    cyc(2);
    chk("cpu_reset_before_3rd_edge", cpu_reset, 1'b0);
    cyc(1);
    chk("cpu_reset_at_3rd_edge", cpu_reset, 1'b1);
    chk("load_done_cleared", {load_done, load_done_s}, 2'b00);
    chk("overflow_cleared", {overflow, overflow_s}, 2'b00);
    chk("word_count_cleared", word_count, 0);
  endtask

  task automatic wait_run(input int bound, output int cycles);
    cycles = 0;
    while (cpu_reset && cycles < bound) begin
      cyc(1);
      cycles++;
    end
    chk("release_timeout", cpu_reset, 1'b0);
  endtask

  task automatic exit_load();
    int c;
    mode_sw = 1'b0;
    wait_run(40, c);
    chk("release_edges", c, EXIT_EDGES);
  endtask

  // Model: every complete group of 4 bytes is one big-endian word at the next address
  task automatic check_session(input string tag, input int nw);
    int ns;
    logic [31:0] w;
    ns = (nw > int'(SMALL_MAX)) ? int'(SMALL_MAX) : nw;
    chk({tag, "_nwrites"}, q_main.size(), nw);
    for (int i = 0; i < nw && i < q_main.size(); i++) begin
      w = {sent[4*i], sent[4*i+1], sent[4*i+2], sent[4*i+3]};
      chk($sformatf("%s_addr%0d", tag, i), q_main[i].addr, i);
      chk($sformatf("%s_data%0d", tag, i), q_main[i].data, w);
    end
    chk({tag, "_word_count"}, word_count, nw);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_load_done"}, load_done, 1'b1);
    chk({tag, "_small_nwrites"}, q_small.size(), ns);
    for (int i = 0; i < ns && i < q_small.size(); i++) begin
      w = {sent[4*i], sent[4*i+1], sent[4*i+2], sent[4*i+3]};
      chk($sformatf("%s_small_addr%0d", tag, i), q_small[i].addr, i);
      chk($sformatf("%s_small_data%0d", tag, i), q_small[i].data, w);
    end
    chk({tag, "_small_word_count"}, word_count_s, ns);
    chk({tag, "_small_overflow"}, overflow_s, nw > int'(SMALL_MAX));
    chk({tag, "_small_load_done"}, load_done_s, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int   c;
    int   nb;
    vecs[0] = '{4, '{8'h24, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 32'h24080001};
    vecs[1] = '{6, '{8'hde, 8'had, 8'hbe, 8'hef, 8'h11, 8'h22, 8'h00, 8'h00}, 1, 32'hdeadbeef};
    vecs[2] = '{3, '{8'hff, 8'hee, 8'hdd, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 32'h0};
    vecs[3] = '{8, '{8'ha5, 8'h5a, 8'hc3, 8'h3c, 8'h01, 8'h02, 8'h03, 8'h04}, 2, 32'ha55ac33c};

    // Reset then run
    fetch_addr = 14'h0005;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk("reset_rom_addr", rom_addr, 14'h0005);
    chk("reset_rom_we", rom_we, 1'b0);
    chk("reset_cpu_reset", cpu_reset, 1'b0);
    chk("reset_word_count", word_count, 0);
    chk("reset_flags", {load_done, overflow}, 2'b00);
    chk("reset_rom_wdata", rom_wdata, 32'h0);

    // Single-word load with cycle-exact write pulse
    start_session();
    fetch_addr = 14'h03ff;
    enter_load();
    chk("load_rom_addr_is_wptr", rom_addr, 14'h0000);
    send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h01);
    chk("single_we_after_4th", rom_we, 1'b0);
    cyc(1);
    chk("single_we_pulse", rom_we, 1'b1);
    chk("single_addr", rom_addr, 14'h0000);
    chk("single_wdata", rom_wdata, 32'h24080001);
    cyc(1);
    chk("single_we_end", rom_we, 1'b0);
    chk("single_count", word_count, 1);
    chk("single_wdata_held", rom_wdata, 32'h24080001);
    fetch_addr = '0;
    exit_load();
    check_session("single", 1);

    // Table of short loads
    for (int v = 0; v < 4; v++) begin
      start_session();
      enter_load();
      for (int j = 0; j < vecs[v].nb; j++) send_byte(vecs[v].b[j]);
      cyc(3);
      exit_load();
      check_session($sformatf("vec%0d", v), vecs[v].nw);
      if (vecs[v].nw > 0 && q_main.size() > 0)
        chk($sformatf("vec%0d_w0", v), q_main[0].data, vecs[v].w0);
    end

    // Back-to-back bytes 0..7
    start_session();
    enter_load();
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    cyc(3);
    exit_load();
    check_session("b2b", 2);
    if (q_main.size() == 2) begin
      chk("b2b_w0", q_main[0].data, 32'h00010203);
      chk("b2b_w1", q_main[1].data, 32'h04050607);
    end

    // Partial word discarded at exit
    start_session();
    enter_load();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i));
    cyc(3);
    mode_sw = 1'b0;
    cyc(3);
    chk("partial_in_release", cpu_reset, 1'b1);
    chk("partial_byte_cnt", dut.byte_cnt, 2'd0);
    wait_run(40, c);
    check_session("partial", 1);

    // 4th byte on the edge where mode_s falls
    start_session();
    enter_load();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    cyc(2);
    mode_sw = 1'b0;
    cyc(1);
    send_byte(8'h44);
    chk("race_we_pending", rom_we, 1'b0);
    cyc(1);
    chk("race_we_in_release", rom_we, 1'b1);
    chk("race_cpu_reset", cpu_reset, 1'b1);
    chk("race_addr", rom_addr, 14'h0000);
    chk("race_wdata", rom_wdata, 32'h11223344);
    wait_run(40, c);
    check_session("race", 1);

    // Overflow on the MAX_WORDS=2 instance
    start_session();
    enter_load();
    for (int i = 0; i < 12; i++) send_byte(8'(8'h80 + i));
    cyc(3);
    exit_load();
    check_session("ovf", 3);

    // Reset mid-load drops the pending write
    start_session();
    enter_load();
    send_byte(8'hca); send_byte(8'hfe); send_byte(8'hba); send_byte(8'hbe);
    reset   = 1'b0;
    mode_sw = 1'b0;
    cyc(1);
    chk("rst_mid_we", rom_we, 1'b0);
    chk("rst_mid_cpu_reset", cpu_reset, 1'b0);
    chk("rst_mid_load_done", load_done, 1'b0);
    reset = 1'b1;
    cyc(4);
    chk("rst_mid_no_write", q_main.size(), 0);
    chk("rst_mid_state", dut.state, dut.S_RUN);
    chk("rst_mid_after_cpu_reset", cpu_reset, 1'b0);

    // Randomized loads against the word model, with run-mode passthrough checks
    for (int s = 0; s < 20; s++) begin
      fetch_addr = ADDR_W'($urandom);
      #1;
      chk($sformatf("rnd%0d_passthru", s), rom_addr, fetch_addr);
      cyc(1);
      start_session();
      fetch_addr = '0;
      enter_load();
      nb = int'($urandom_range(0, 14));
      for (int j = 0; j < nb; j++) begin
        cyc(int'($urandom_range(0, 2)));
        send_byte(8'($urandom));
      end
      cyc(3);
      exit_load();
      check_session($sformatf("rnd%0d", s), nb / 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_load_arbiter.md
# imem_load_arbiter

Owns the instruction-memory port and shares it between the CPU fetch unit and the UART program loader. In run mode the fetch unit's word address passes straight through to the program ROM. In load mode the CPU is held in reset, UART bytes are assembled into 32-bit words and written sequentially from word 0, and on exit the CPU is released so it restarts at PC 0. It sits between the UART receiver, the board mode switch, the fetch unit and the program ROM.

## Interface
- ADDR_W, 14: ROM word-address width; matches PC[15:2].
- MAX_WORDS, 16384: words accepted per load. Must be ≤ 2^ADDR_W.
- HOLD_CYCLES, 4: cycles cpu_reset stays high after leaving load mode. Must be ≥ 1.
- clock  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-low. Sampled at a rising edge of clock; 0 resets the block.
- mode_sw  in  1  asynchronous board switch; 1 requests load mode.
- uart_valid  in  1  one-cycle strobe: uart_byte is valid.
- uart_byte  in  8  received byte.
- fetch_addr  in  ADDR_W  word address from the fetch unit.
- rom_addr  out  ADDR_W  ROM address.
- rom_we  out  1  ROM write enable.
- rom_wdata  out  32  ROM write data.
- cpu_reset  out  1  active-high reset to the CPU core, including the fetch unit.
- load_done  out  1  sticky: the last load completed. Cleared on entry to LOAD.
- overflow  out  1  sticky: bytes arrived after MAX_WORDS words were stored. Cleared on entry to LOAD.
- word_count  out  ADDR_W+1  words written in the current or last load.

## Operation
- mode_sw passes through a 2-flop synchronizer; mode_s is the second flop. The FSM uses only mode_s.
- States: RUN, LOAD, RELEASE. Reset enters RUN.
- RUN:
  - rom_addr = fetch_addr, combinationally muxed (the ROM read is synchronous).
  - rom_we = 0, cpu_reset = 0.
  - mode_s = 1 → LOAD. On that transition clear wptr, byte_cnt, word_count, load_done and overflow.
- LOAD:
  - cpu_reset = 1; rom_addr = wptr.
  - Each uart_valid shifts uart_byte into shreg: shreg <= {shreg[23:0], uart_byte}. The first byte received ends up in bits [31:24] (big-endian).
  - byte_cnt counts 0..3. When uart_valid arrives with byte_cnt = 3:
    - if wptr < MAX_WORDS, set the pending-write flag and reset byte_cnt to 0;
    - otherwise drop the word and set overflow.
  - The cycle after the pending flag is set:
    - rom_we = 1 for exactly one cycle;
    - rom_wdata = the assembled word, held stable during the pulse;
    - rom_addr = wptr.
    - At the end of that cycle, wptr and word_count increment.
  - mode_s = 0 → RELEASE. Any partial word (byte_cnt ≠ 0) is discarded and byte_cnt is cleared.
- RELEASE:
  - cpu_reset = 1; uart_valid is ignored.
  - A write still pending from LOAD is committed in the first RELEASE cycle at the LOAD-time wptr.
  - A counter runs HOLD_CYCLES cycles. Then load_done <= 1 and the FSM goes to RUN.
  - mode_s returning to 1 during RELEASE is acted on only after the FSM reaches RUN.
- rom_wdata holds its last value outside write pulses; only rom_we qualifies it.
- Reset values: FSM = RUN, cpu_reset = 0, rom_we = 0, rom_wdata = 0, load_done = 0, overflow = 0, word_count = 0, wptr = 0, byte_cnt = 0, both synchronizer flops = 0. rom_addr = fetch_addr.
- reset low while in LOAD aborts the load: no write is issued and the pending write is dropped. load_done stays 0.

## Timing
- mode_sw rising to cpu_reset high: 3 rising edges (2 synchronizer + 1 FSM).
- 4th byte strobe at edge N: rom_we is high in cycle N+1; wptr increments at edge N+2.
- Minimum uart_valid spacing is 1 cycle. Back-to-back words are accepted, because the pending flag and shreg hold independently of the next byte.
- mode_s falling to cpu_reset low: HOLD_CYCLES + 1 edges. The fetch unit sees cpu_reset = 0 while fetch_addr = 0.
- Overflow is detected at the 4th-byte edge. No rom_we is generated for dropped words.

## Test plan
- Reset then run: reset = 0 for 2 cycles, then 1, fetch_addr = 0x0005 → rom_addr = 0x0005, rom_we = 0, cpu_reset = 0, word_count = 0.
- Single-word load: mode_sw = 1, then bytes 0x24, 0x08, 0x00, 0x01 → one rom_we pulse with rom_addr = 0, rom_wdata = 0x24080001, word_count = 1. Then mode_sw = 0 → cpu_reset falls HOLD_CYCLES + 1 edges after mode_s falls, and load_done = 1.
- Back-to-back bytes: 8 consecutive uart_valid cycles, bytes 0x00..0x07 → writes 0x00010203 at addr 0 and 0x04050607 at addr 1, each a 1-cycle pulse. word_count = 2.
- Partial word and exit race:
  - 6 bytes, then mode_sw = 0 → only word 0 is written; byte_cnt = 0 in RELEASE.
  - 4th byte on the same edge that mode_s falls → that word is still written in the first RELEASE cycle.
- Overflow with MAX_WORDS = 2: 12 bytes → writes at addr 0 and 1 only, overflow = 1, word_count = 2.
- Reset mid-load: reset = 0 on the edge after the 4th byte → no rom_we, FSM = RUN, cpu_reset = 0, load_done = 0.
